// File: rtl/i2c_slave_rx_if.sv
// Receive-side result bundle of the I2C write responder.
//   rx_data   : last completed 16-bit payload {byte1, byte2}
//   rx_valid  : one-cycle strobe when rx_data updates
//   frame_err : one-cycle strobe when an addressed frame is aborted
//   busy      : high from detected START to detected STOP
// The master modport is the responder (producer); slave is the consumer.
interface i2c_slave_rx_if;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        busy;

    modport master (output rx_data, output rx_valid, output frame_err, output busy);
    modport slave  (input  rx_data, input  rx_valid, input  frame_err, input  busy);
endinterface

// File: rtl/i2c_slave_rx.sv
// I2C write-only responder: receives {address, byte1, byte2} frames,
// ACKs only its own write address, and presents each completed 16-bit
// payload with a one-cycle valid strobe. SCL/SDA are oversampled on
// clock_i2c; no clock stretching.
//   clock_i2c : sampling clock (rising edge)
//   rst       : asynchronous active-high reset
//   i2c_sclk  : bus SCL input
//   i2c_sdin  : bus SDA, open-drain (driven 0 or released)
//   rx        : result bundle (rx_data, rx_valid, frame_err, busy)
module i2c_slave_rx #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic              clock_i2c,
    input  logic              rst,
    input  logic              i2c_sclk,
    inout  wire               i2c_sdin,
    i2c_slave_rx_if.master    rx
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ACK_A, ST_DATA1, ST_ACK_1,
        ST_DATA2, ST_ACK_2, ST_WAIT_STOP, ST_IGNORE
    } state_t;

    state_t      state_r, state_next_s;
    logic        scl_s1_r, scl_s2_r, scl_h_r;
    logic        sda_s1_r, sda_s2_r, sda_h_r;
    logic        scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [2:0]  bit_cnt_r;
    logic        byte_full_r;
    logic [7:0]  shift_r, byte1_r;
    logic [15:0] rx_data_r;
    logic        valid_pend_r, rx_valid_r, frame_err_r, busy_r, sda_oe_r;
    logic        shift_en_s, cnt_clr_s, load_byte1_s, load_rx_s, err_s, aborting_s;

    // Open-drain SDA: only ever pull low or release.
    assign i2c_sdin = sda_oe_r ? 1'b0 : 1'bz;

    assign rx.rx_data   = rx_data_r;
    assign rx.rx_valid  = rx_valid_r;
    assign rx.frame_err = frame_err_r;
    assign rx.busy      = busy_r;

    // Two-flop synchronizers plus one history stage; reset to idle-high bus.
    always_ff @(posedge clock_i2c or posedge rst) begin
        if (rst) begin
            {scl_s1_r, scl_s2_r, scl_h_r} <= 3'b111;
            {sda_s1_r, sda_s2_r, sda_h_r} <= 3'b111;
        end else begin
            {scl_s1_r, scl_s2_r, scl_h_r} <= {i2c_sclk, scl_s1_r, scl_s2_r};
            {sda_s1_r, sda_s2_r, sda_h_r} <= {i2c_sdin, sda_s1_r, sda_s2_r};
        end
    end

    assign scl_rise_s = scl_s2_r & ~scl_h_r;
    assign scl_fall_s = ~scl_s2_r & scl_h_r;
    // START/STOP only count while SCL was high on both samples.
    assign start_s    = scl_s2_r & scl_h_r & sda_h_r & ~sda_s2_r;
    assign stop_s     = scl_s2_r & scl_h_r & ~sda_h_r & sda_s2_r;

    // States in which the master has been ACKed but the payload is not yet complete.
    assign aborting_s = (state_r == ST_ACK_A) || (state_r == ST_DATA1) ||
                        (state_r == ST_ACK_1) || (state_r == ST_DATA2);

    // FSM state register.
    always_ff @(posedge clock_i2c or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath control; START/STOP override bit handling.
    always_comb begin
        state_next_s = state_r;
        shift_en_s   = 1'b0;
        cnt_clr_s    = 1'b0;
        load_byte1_s = 1'b0;
        load_rx_s    = 1'b0;
        err_s        = 1'b0;
        if (start_s) begin
            state_next_s = ST_ADDR;
            cnt_clr_s    = 1'b1;
            err_s        = aborting_s;
        end else if (stop_s) begin
            state_next_s = ST_IDLE;
            cnt_clr_s    = 1'b1;
            err_s        = aborting_s;
        end else begin
            case (state_r)
                ST_ADDR: begin
                    if (scl_rise_s) begin
                        shift_en_s = 1'b1;
                    end else if (scl_fall_s && byte_full_r) begin
                        cnt_clr_s = 1'b1;
                        if (shift_r == {DEV_ADDR, 1'b0}) begin
                            state_next_s = ST_ACK_A;
                        end else begin
                            state_next_s = ST_IGNORE;
                        end
                    end else begin
                        state_next_s = ST_ADDR;
                    end
                end
                ST_DATA1: begin
                    if (scl_rise_s) begin
                        shift_en_s = 1'b1;
                    end else if (scl_fall_s && byte_full_r) begin
                        cnt_clr_s    = 1'b1;
                        load_byte1_s = 1'b1;
                        state_next_s = ST_ACK_1;
                    end else begin
                        state_next_s = ST_DATA1;
                    end
                end
                ST_DATA2: begin
                    if (scl_rise_s) begin
                        shift_en_s = 1'b1;
                        load_rx_s  = (bit_cnt_r == 3'd7);
                    end else if (scl_fall_s && byte_full_r) begin
                        cnt_clr_s    = 1'b1;
                        state_next_s = ST_ACK_2;
                    end else begin
                        state_next_s = ST_DATA2;
                    end
                end
                ST_ACK_A: begin
                    if (scl_fall_s) begin
                        state_next_s = ST_DATA1;
                    end else begin
                        state_next_s = ST_ACK_A;
                    end
                end
                ST_ACK_1: begin
                    if (scl_fall_s) begin
                        state_next_s = ST_DATA2;
                    end else begin
                        state_next_s = ST_ACK_1;
                    end
                end
                ST_ACK_2: begin
                    if (scl_fall_s) begin
                        state_next_s = ST_WAIT_STOP;
                    end else begin
                        state_next_s = ST_ACK_2;
                    end
                end
                ST_IDLE:      state_next_s = ST_IDLE;
                ST_WAIT_STOP: state_next_s = ST_WAIT_STOP;
                ST_IGNORE:    state_next_s = ST_IGNORE;
                default:      state_next_s = ST_IDLE;
            endcase
        end
    end

    // Shift register, bit counter and captured first data byte.
    always_ff @(posedge clock_i2c or posedge rst) begin
        if (rst) begin
            shift_r     <= 8'h00;
            bit_cnt_r   <= 3'd0;
            byte_full_r <= 1'b0;
            byte1_r     <= 8'h00;
        end else begin
            if (cnt_clr_s) begin
                bit_cnt_r   <= 3'd0;
                byte_full_r <= 1'b0;
            end else if (shift_en_s) begin
                shift_r     <= {shift_r[6:0], sda_s2_r};
                bit_cnt_r   <= bit_cnt_r + 3'd1;
                byte_full_r <= (bit_cnt_r == 3'd7);
            end else begin
                bit_cnt_r   <= bit_cnt_r;
            end
            if (load_byte1_s) begin
                byte1_r <= shift_r;
            end else begin
                byte1_r <= byte1_r;
            end
        end
    end

    // Registered outputs; ACK drive follows the state one cycle later.
    always_ff @(posedge clock_i2c or posedge rst) begin
        if (rst) begin
            rx_data_r    <= 16'h0000;
            valid_pend_r <= 1'b0;
            rx_valid_r   <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
            sda_oe_r     <= 1'b0;
        end else begin
            if (load_rx_s) begin
                rx_data_r <= {byte1_r, shift_r[6:0], sda_s2_r};
            end else begin
                rx_data_r <= rx_data_r;
            end
            valid_pend_r <= load_rx_s;
            rx_valid_r   <= valid_pend_r;
            frame_err_r  <= err_s;
            busy_r       <= (state_next_s != ST_IDLE);
            sda_oe_r     <= (state_r == ST_ACK_A) || (state_r == ST_ACK_1) ||
                            (state_r == ST_ACK_2);
        end
    end

endmodule

// File: doc/i2c_slave_rx.md
# i2c_slave_rx

I2C write-only responder that receives the 24-bit frames produced by the codec configuration master: device address byte plus two data bytes. It is the far end of the configuration bus. It serves as an on-chip register sink for codec-style peripherals and as a bus-functional responder in the configuration-path testbench. It oversamples SCL/SDA on `clock_i2c` and detects START/STOP. It ACKs only its own write address and presents each completed 16-bit payload with a one-cycle valid strobe.

## Interface
- `DEV_ADDR`, default 7'h1A: 7-bit responder address. Write address byte is 0x34.
- `clock_i2c`  in  1  sampling clock, rising edge. SCL high and low phases must each be ≥4 periods.
- `rst`  in  1  reset, asynchronous, active-high.
- `i2c_sclk`  in  1  bus SCL; input only, no clock stretching.
- `i2c_sdin`  inout  1  bus SDA, open-drain: driven 0 when `sda_oe`=1, otherwise z.
- `rx_data`  out  16  last completed payload, {byte1, byte2}. For codec use, [15:9] is the register address and [8:0] is the value.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `frame_err`  out  1  one-cycle pulse on an aborted addressed frame.
- `busy`  out  1  high from detected START to detected STOP.

## Operation
- Input conditioning:
  - SCL and SDA each pass through a 2-flop synchronizer, then one history register.
  - Edges: `scl_rise`, `scl_fall`.
  - START = SDA falls while SCL is high. STOP = SDA rises while SCL is high.
- Bit order is MSB first. Data bits are sampled on `scl_rise`. SDA drive changes only on `scl_fall`.
- States: IDLE, ADDR, ACK_A, DATA1, ACK_1, DATA2, ACK_2, WAIT_STOP, IGNORE.
- 3-bit bit counter, reset on START and at each byte boundary.
- IDLE: START → ADDR, `busy`=1.
- ADDR: shift 8 bits.
  - On the `scl_fall` after bit 8, check the byte. If it equals {DEV_ADDR, 0}: `sda_oe`=1 → ACK_A.
  - Otherwise (address mismatch, or R/W=1): → IGNORE, SDA stays released (NACK).
- ACK_A / ACK_1 / ACK_2:
  - Hold `sda_oe`=1 through the 9th SCL high.
  - On the following `scl_fall`: `sda_oe`=0, advance to DATA1 / DATA2 / WAIT_STOP.
- DATA1: shift 8 bits into `byte1`. The `scl_fall` after bit 8 drives ACK → ACK_1.
- DATA2: shift 8 bits.
  - On the `scl_rise` sampling bit 8: `rx_data`←{byte1, byte2[6:0], sda}, and pulse `rx_valid` the next cycle.
  - The following `scl_fall` drives ACK → ACK_2.
- WAIT_STOP: any further bytes are NACKed (SDA released); payload unchanged.
- IGNORE: SDA released; waits for STOP or START.
- STOP in any state → IDLE, `busy`=0, `sda_oe`=0.
  - If the state was ADDR-after-match, ACK_A, DATA1, ACK_1 or DATA2, also pulse `frame_err`.
- START (repeated) in any state other than IDLE → ADDR, clear the counter, `sda_oe`=0.
  - `frame_err` follows the same rule as for STOP.
- START/STOP take priority over data-bit shifting when coincident with an edge.
- `rx_data` is never partially updated. It changes only at the valid point.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `busy`=0, `sda_oe`=0 (SDA released), state IDLE, synchronizer flops = 1 (idle-high bus).
- Reset is asynchronous: SDA is released immediately even mid-ACK, and no pulse is generated.
- Detection latency: a pin change is visible to the FSM 3 `clock_i2c` edges after it occurs.
- SDA drive latency: `sda_oe` changes on the cycle after the FSM sees `scl_fall`, i.e. 4 cycles after the SCL pin falls.
  - This must be shorter than SCL low minus master setup. Hence the ≥4-period low-phase requirement.
- ACK is held stable for the entire 9th SCL high phase. It is released 4 cycles after the 9th SCL falls.
- `rx_valid` is 1 cycle wide, asserted 4 cycles after the SCL pin rises on bit 8 of byte 2. `rx_data` is stable from that cycle.
- `frame_err` is 1 cycle wide, asserted on the cycle after the START/STOP is detected.
- Back-to-back frames: a STOP followed immediately by a START is accepted with no dead cycles beyond detection latency.

## Test plan
- Frame 0x34, 0x1E, 0x00 with STOP:
  - SDA is pulled low on all three 9th clocks.
  - `rx_data`=16'h1E00.
  - `rx_valid` pulses exactly once.
  - `frame_err`=0; `busy` falls after STOP.
- Address byte 0x36, then two bytes:
  - SDA is high on every 9th clock.
  - No `rx_valid`, no `frame_err`.
  - `rx_data` is unchanged.
- Read address 0x35: NACK, state IGNORE, and the bus is released through STOP.
- 0x34, 0x12, then STOP after 4 bits of byte 2:
  - `frame_err` is a 1-cycle pulse.
  - No `rx_valid`; `rx_data` keeps its previous value.
  - A repeated START mid-DATA1, followed by a full 0x34/0xAB/0xCD frame, yields `frame_err` once, then `rx_data`=16'hABCD.
- 0x34, 0x0C, 0x9F, then a 4th byte 0x55:
  - `rx_data`=16'h0C9F.
  - The 4th byte is NACKed.
  - `rx_valid` pulses only once.
- Assert `rst` while SDA is driven low for ACK_1:
  - SDA is z immediately and all outputs take their reset values.
  - The next complete frame is received correctly.
